// File: rtl/os_drain_pkg.sv
// os_drain_pkg: shared state encoding and column mode constants for the OS psum drain
package os_drain_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, WAIT, FLUSH} state_t;
  localparam logic MODE_OS = 1'b1;
  localparam logic MODE_WS = 1'b0;
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: circular capture buffer with head-driven output and occupancy count
module psum_fifo #(
  parameter int width = 17,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic [$clog2(depth):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wp, rp;
  // storage and pointers; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (aw+1)'(push) - (aw+1)'(pop);
    end
  assign dout = mem[rp];
  assign empty = count == '0;
  assign full = count == (aw+1)'(depth);
endmodule

// File: rtl/os_psum_drain.sv
// os_psum_drain: shifts OS psums out of one PE column, buffers them and streams them with a last tag
module os_psum_drain import os_drain_pkg::*; #(
  parameter int psum_bw = 16,
  parameter int row = 8,
  parameter int fifo_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [psum_bw-1:0] col_psum,
  output logic               col_mode,
  output logic               drain_en,
  output logic [psum_bw-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);
  localparam int cw = $clog2(row + 1);
  localparam int fw = $clog2(fifo_depth) + 1;
  state_t state, state_n;
  logic [cw-1:0] iss, cap;
  logic cap_q, pop, fifo_empty, fifo_full;
  logic [fw-1:0] fifo_count;
  logic [fw:0] occ;
  logic [psum_bw:0] head;
  assign pop = out_valid & out_ready;
  assign occ = {1'b0, fifo_count} + (fw+1)'(cap_q) - (fw+1)'(pop);
  psum_fifo #(.width(psum_bw + 1), .depth(fifo_depth)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(cap_q & ~fifo_full),
    .pop(pop),
    .din({cap == cw'(row - 1), col_psum}),
    .dout(head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  assign out_valid = ~fifo_empty;
  assign out_data = head[psum_bw-1:0];
  assign out_last = out_valid & head[psum_bw];
  assign busy = state != IDLE;
  // next state and column controls; a shift is issued only when its capture is sure to find a slot
  always_comb begin
    state_n = state;
    col_mode = MODE_WS;
    drain_en = 1'b0;
    case (state)
      IDLE: begin
        col_mode = MODE_OS;
        state_n = start ? DRAIN : IDLE;
      end
      DRAIN: begin
        drain_en = iss < cw'(row) && occ < (fw+1)'(fifo_depth);
        state_n = iss == cw'(row) ? WAIT : DRAIN;
      end
      WAIT: state_n = cap == cw'(row) ? FLUSH : WAIT;
      FLUSH: begin
        col_mode = MODE_OS;
        state_n = fifo_empty ? IDLE : FLUSH;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, issue/capture counters, in-flight capture flag and done pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      iss <= '0;
      cap <= '0;
      cap_q <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cap_q <= drain_en;
      done <= pop & out_last;
      iss <= (state == IDLE && start) ? '0 : iss + cw'(drain_en);
      cap <= (state == IDLE && start) ? '0 : cap + cw'(cap_q);
    end
endmodule

// File: tb/tb_os_psum_drain.sv
// tb_os_psum_drain: scoreboard bench driving three drain instances (row 4, 8, 1) with a behavioural column
module tb_os_psum_drain;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic out_ready = 1'b1;
  logic start_v [3] = '{default: 1'b0};
  logic [15:0] col_psum_v [3];
  logic [15:0] out_data_v [3];
  logic col_mode_v [3], drain_en_v [3], out_valid_v [3], out_last_v [3], busy_v [3], done_v [3], pwf [3];
  logic [2:0] cnt_v [3];
  logic [15:0] vals [8];
  logic [16:0] exp_q [$];
  int sel = 0;
  int checks = 0;
  int errors = 0;
  int den_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int R = g == 0 ? 4 : g == 1 ? 8 : 1;
    int idx;
    logic [15:0] col;
    os_psum_drain #(.psum_bw(16), .row(R), .fifo_depth(4)) u (
      .clk(clk),
      .reset(reset),
      .start(start_v[g]),
      .col_psum(col_psum_v[g]),
      .col_mode(col_mode_v[g]),
      .drain_en(drain_en_v[g]),
      .out_data(out_data_v[g]),
      .out_valid(out_valid_v[g]),
      .out_last(out_last_v[g]),
      .out_ready(out_ready),
      .busy(busy_v[g]),
      .done(done_v[g])
    );
    // column model: each qualified shift presents the next psum on the following cycle
    always @(posedge clk or negedge reset)
      if (!reset) begin
        idx <= 0;
        col <= '0;
      end else if (start_v[g] && !busy_v[g]) idx <= 0;
      else if (drain_en_v[g]) begin
        col <= vals[idx[2:0]];
        idx <= idx + 1;
      end
    assign col_psum_v[g] = col;
    assign pwf[g] = u.cap_q & u.fifo_full;
    assign cnt_v[g] = u.fifo_count;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, x);
    end
  endtask

  task automatic monitor();
    logic hold = 1'b0;
    logic done_exp = 1'b0;
    logic [15:0] hd = '0;
    logic hl = 1'b0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold = 1'b0;
        done_exp = 1'b0;
      end else begin
        chk("push_while_full", pwf[sel], 0);
        if (drain_en_v[sel]) den_cnt++;
        if (done_exp) begin
          chk("done_pulse", done_v[sel], 1);
          done_cnt++;
          done_exp = 1'b0;
        end else if (done_v[sel]) chk("done_spurious", done_v[sel], 0);
        if (hold) begin
          chk("hold_valid", out_valid_v[sel], 1);
          chk("hold_data", out_data_v[sel], hd);
          chk("hold_last", out_last_v[sel], hl);
        end
        if (out_valid_v[sel] && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got 0x%0h expected no word", out_data_v[sel]);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data_v[sel], e[15:0]);
            chk("out_last", out_last_v[sel], e[16]);
            if (e[16]) done_exp = 1'b1;
          end
        end
        hold = out_valid_v[sel] && !out_ready;
        hd = out_data_v[sel];
        hl = out_last_v[sel];
      end
    end
  endtask

  task automatic arm(input int n, input int v0);
    for (int i = 0; i < n; i++) begin
      vals[i] = 16'(v0 + i);
      exp_q.push_back({i == n - 1, vals[i]});
    end
  endtask

  task automatic pulse(input int s);
    start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
  endtask

  task automatic wait_done(input int n, input bit tog);
    int base = done_cnt;
    for (int i = 0; i < n && done_cnt == base; i++) begin
      @(posedge clk);
      #1 if (tog) out_ready = ~out_ready;
    end
    chk("done_seen", done_cnt - base, 1);
  endtask

  initial begin
    int base;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_col_mode", col_mode_v[i], 1);
      chk("rst_drain_en", drain_en_v[i], 0);
      chk("rst_out_valid", out_valid_v[i], 0);
      chk("rst_out_last", out_last_v[i], 0);
      chk("rst_busy", busy_v[i], 0);
      chk("rst_done", done_v[i], 0);
      chk("rst_out_data", out_data_v[i], 0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    // row=4 basic drain with a free-flowing consumer
    sel = 0;
    vals[0] = 16'd33; vals[1] = 16'd18; vals[2] = 16'd6; vals[3] = 16'd0;
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, vals[i]});
    base = den_cnt;
    pulse(0);
    chk("t1_mode_drain", col_mode_v[0], 0);
    chk("t1_busy", busy_v[0], 1);
    wait_done(40, 0);
    chk("t1_issues", den_cnt - base, 4);
    chk("t1_mode_os", col_mode_v[0], 1);
    repeat (2) @(posedge clk);
    #1 chk("t1_idle", busy_v[0], 0);
    // row=8 with the consumer stalled: fill to depth, then release
    sel = 1;
    out_ready = 1'b0;
    arm(8, 1);
    base = den_cnt;
    pulse(1);
    repeat (19) @(posedge clk);
    #1;
    chk("t2_issues_stalled", den_cnt - base, 4);
    chk("t2_drain_en_low", drain_en_v[1], 0);
    chk("t2_count_full", cnt_v[1], 4);
    chk("t2_mode_ws", col_mode_v[1], 0);
    out_ready = 1'b1;
    wait_done(100, 0);
    chk("t2_issues", den_cnt - base, 8);
    // alternating ready
    arm(8, 100);
    pulse(1);
    wait_done(200, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t3_drained", exp_q.size(), 0);
    // second start during DRAIN is ignored
    arm(8, 50);
    base = den_cnt;
    pulse(1);
    repeat (2) @(posedge clk);
    #1 pulse(1);
    wait_done(100, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_words", exp_q.size(), 0);
    chk("t4_issues", den_cnt - base, 8);
    chk("t4_idle", busy_v[1], 0);
    chk("t4_valid", out_valid_v[1], 0);
    // reset mid-DRAIN after three issues, then a clean drain
    out_ready = 1'b0;
    arm(8, 1);
    base = den_cnt;
    pulse(1);
    for (int i = 0; i < 50 && den_cnt - base < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_issues_before_reset", den_cnt - base, 3);
    #2 reset = 1'b0;
    #1;
    chk("t5_col_mode", col_mode_v[1], 1);
    chk("t5_drain_en", drain_en_v[1], 0);
    chk("t5_out_valid", out_valid_v[1], 0);
    chk("t5_out_last", out_last_v[1], 0);
    chk("t5_busy", busy_v[1], 0);
    chk("t5_out_data", out_data_v[1], 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    arm(8, 200);
    base = den_cnt;
    pulse(1);
    wait_done(100, 0);
    chk("t5_issues", den_cnt - base, 8);
    repeat (3) @(posedge clk);
    #1 chk("t5_words", exp_q.size(), 0);
    // row=1 single word at full scale
    sel = 2;
    arm(1, 16'hFFFF);
    pulse(2);
    wait_done(40, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy", busy_v[2], 0);
    chk("t6_valid", out_valid_v[2], 0);
    chk("t6_words", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
